multi_edge_detector: RTL and testbench

MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

---
 rtl/multi_edge_detector.sv | 150 +++++++++++++++
 tb/tb_multi_edge_detector.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector: per-channel synchroniser, 4-state
// debounce FSM, mode-selected one-cycle event pulses and a shared event counter.
`timescale 1ns/1ps
module multi_edge_detector #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_W         = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] w,
    input  logic [1:0]          mode,
    input  logic                clear,
    output logic [CHANNELS-1:0] z,
    output logic [CHANNELS-1:0] level,
    output logic                any_event,
    output logic [COUNT_W-1:0]  event_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int POP_W = $clog2(CHANNELS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    logic w_rise_en;
    logic w_fall_en;

    // Mode only gates the pulse at the accepting edge; the FSMs never see it.
    assign w_rise_en = (mode == 2'b00) || (mode == 2'b10);
    assign w_fall_en = (mode == 2'b01) || (mode == 2'b10);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        state_t                 r_state;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_z;
        logic                   r_level;

        assign w_s      = r_sync[SYNC_STAGES-1];
        assign z[i]     = r_z;
        assign level[i] = r_level;

        // NOTE: every flop here is non-blocking (<=) so all stages sample the
        // pre-edge values; blocking assignments would collapse the sync chain.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_sync  <= '0;
                r_state <= LOW;
                r_cnt   <= '0;
                r_z     <= 1'b0;
                r_level <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w[i]};
                r_z    <= 1'b0;
                unique case (r_state)
                    LOW: begin
                        if (w_s) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                r_state <= HIGH;
                                r_level <= 1'b1;
                                r_z     <= w_rise_en;
                            end else begin
                                r_state <= RISE_CHK;
                                r_cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    RISE_CHK: begin
                        if (!w_s) begin
                            r_state <= LOW;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= HIGH;
                            r_level <= 1'b1;
                            r_z     <= w_rise_en;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    HIGH: begin
                        if (!w_s) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                r_state <= LOW;
                                r_level <= 1'b0;
                                r_z     <= w_fall_en;
                            end else begin
                                r_state <= FALL_CHK;
                                r_cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    FALL_CHK: begin
                        if (w_s) begin
                            r_state <= HIGH;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= LOW;
                            r_level <= 1'b0;
                            r_z     <= w_fall_en;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic [POP_W-1:0]   w_pop;
    logic [COUNT_W-1:0] r_count;

    // NOTE: w_pop gets a default before the loop so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_pop = w_pop + POP_W'(z[i]);
        end
    end

    // Counts the pulses visible on z; a clear in the same cycle discards them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + COUNT_W'(w_pop);
        end
    end

    assign any_event   = |z;
    assign event_count = r_count;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector at default parameters: latency,
// glitch rejection, edge modes, simultaneous events, clear, wrap and reset.
`timescale 1ns/1ps
module tb_multi_edge_detector;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] w;
    logic [1:0] mode;
    logic       clear;
    logic [3:0] z;
    logic [3:0] level;
    logic       any_event;
    logic [7:0] event_count;

    int checks = 0;
    int errors = 0;
    int hits_a;
    int hits_b;

    multi_edge_detector dut (
        .clock       (clock),
        .reset       (reset),
        .w           (w),
        .mode        (mode),
        .clear       (clear),
        .z           (z),
        .level       (level),
        .any_event   (any_event),
        .event_count (event_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1ns so outputs are sampled away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        w     = 4'b0000;
        mode  = 2'b00;
        clear = 1'b0;
        #3;
        check("rst_z", z, 4'h0);
        check("rst_level", level, 4'h0);
        check("rst_any", any_event, 1'b0);
        check("rst_count", event_count, 8'd0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (4) tick();
        check("idle_z", z, 4'h0);

        // Single rise on channel 0, mode rising: pulse in cycle after edge 5.
        w = 4'b0001;
        repeat (5) tick();
        check("lat_e4_z", z, 4'h0);
        check("lat_e4_level", level, 4'h0);
        tick();
        check("lat_e5_z", z, 4'b0001);
        check("lat_e5_level", level, 4'b0001);
        check("lat_e5_any", any_event, 1'b1);
        tick();
        check("lat_e6_z", z, 4'h0);
        check("lat_e6_count", event_count, 8'd1);

        // Two-cycle glitch on channel 1 in mode both.
        mode = 2'b10;
        w = 4'b0011;
        repeat (2) tick();
        w = 4'b0001;
        hits_a = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (z[1] || level[1]) hits_a++;
        end
        check("glitch_seen", hits_a, 0);
        check("glitch_level", level, 4'b0001);
        check("glitch_count", event_count, 8'd1);

        // Channel 2 rise then fall, mode both.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_count", event_count, 8'd0);
        w = 4'b0101;
        hits_a = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (z[2]) hits_a++;
        end
        check("both_rise_pulses", hits_a, 1);
        check("both_rise_level", level, 4'b0101);
        w = 4'b0001;
        hits_b = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (z[2]) hits_b++;
        end
        check("both_fall_pulses", hits_b, 1);
        check("both_fall_level", level, 4'b0001);
        check("both_count", event_count, 8'd2);

        // Same with all pulses masked: levels still follow.
        mode = 2'b11;
        w = 4'b0101;
        hits_a = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (z != 4'h0) hits_a++;
        end
        check("mask_rise_pulses", hits_a, 0);
        check("mask_rise_level", level, 4'b0101);
        w = 4'b0001;
        hits_b = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (z != 4'h0) hits_b++;
        end
        check("mask_fall_pulses", hits_b, 0);
        check("mask_fall_level", level, 4'b0001);
        check("mask_count", event_count, 8'd2);

        // All four channels rise together, mode rising.
        mode = 2'b00;
        w = 4'b0000;
        repeat (10) tick();
        check("fall_ignored_count", event_count, 8'd2);
        w = 4'b1111;
        repeat (5) tick();
        check("all_e4_z", z, 4'h0);
        tick();
        check("all_e5_z", z, 4'hF);
        check("all_e5_any", any_event, 1'b1);
        tick();
        check("all_e6_z", z, 4'h0);
        check("all_e6_any", any_event, 1'b0);
        check("all_count", event_count, 8'd6);
        w = 4'b0000;
        repeat (10) tick();
        check("all_fall_count", event_count, 8'd6);
        w = 4'b1111;
        repeat (6) tick();
        check("clr_e5_z", z, 4'hF);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_priority_count", event_count, 8'd0);

        // Wrap: 63 flips of four channels, then three, then one.
        mode = 2'b10;
        for (int k = 0; k < 63; k++) begin
            w = ~w;
            repeat (8) tick();
        end
        check("wrap_252", event_count, 8'd252);
        w = 4'b0111;
        repeat (8) tick();
        check("wrap_255", event_count, 8'd255);
        w = 4'b0110;
        repeat (8) tick();
        check("wrap_0", event_count, 8'd0);

        // Reset in the middle of a rise check on channel 3.
        w = 4'b0001;
        repeat (10) tick();
        check("pre_rst_level", level, 4'b0001);
        check("pre_rst_count", event_count, 8'd3);
        w = 4'b1001;
        repeat (3) tick();
        check("mid_chk_z", z, 4'h0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_z", z, 4'h0);
        check("async_rst_level", level, 4'h0);
        check("async_rst_any", any_event, 1'b0);
        check("async_rst_count", event_count, 8'd0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (5) tick();
        check("rel_e4_z", z, 4'h0);
        tick();
        check("rel_e5_z", z, 4'b1001);
        check("rel_e5_level", level, 4'b1001);
        tick();
        check("rel_e6_z", z, 4'h0);
        check("rel_count", event_count, 8'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
